// File: rtl/axi_to_mem_pkg.sv
// Shared types for the axi_to_mem read/write sequencers: AXI burst encodings
// and the burst sequencer FSM state.
package axi_to_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } ar_state_e;

endpackage

// File: rtl/axi_burst_addr_next.sv
// Combinational AXI next-beat address calculator (FIXED / INCR / WRAP).
// Shared by the read and write burst sequencers.
module axi_burst_addr_next
  import axi_to_mem_pkg::*;
#(
  parameter int AddrWidth = 32
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [2:0]           size,
  input  logic [7:0]           len,
  input  logic [1:0]           burst,
  output logic [AddrWidth-1:0] next_addr
);

  logic [AddrWidth-1:0] bytes;
  logic [AddrWidth-1:0] aligned;
  logic [AddrWidth-1:0] wsize;
  logic [AddrWidth-1:0] base;

  always_comb begin
    bytes   = AddrWidth'(1) << size;
    aligned = addr & ~(bytes - AddrWidth'(1));
    wsize   = bytes * (AddrWidth'(len) + AddrWidth'(1));
    base    = addr & ~(wsize - AddrWidth'(1));
    next_addr = aligned + bytes;
    // Reserved burst type 2'b11 falls through to INCR behaviour.
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = base | ((aligned + bytes) & (wsize - AddrWidth'(1)));
      default:     next_addr = aligned + bytes;
    endcase
  end

endmodule

// File: rtl/axi_ar_burst_seq.sv
// AXI read-burst sequencer: pops AR requests and issues one memory read per beat,
// bounded by an outstanding-beat credit counter. Optional AXI_AR_BURST_SEQ_PERF_EN adds perf counters.
module axi_ar_burst_seq
  import axi_to_mem_pkg::*;
#(
  parameter int IdWidth        = 4,
  parameter int MemAddrWidth   = 32,
  parameter int UserWidth      = 1,
  parameter int DataWidth      = 64,
  parameter int MaxOutstanding = 8,
  parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ar_empty_i,
  input  logic [IdWidth-1:0]      ar_id_i,
  input  logic [MemAddrWidth-1:0] ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  input  logic [UserWidth-1:0]    ar_user_i,
  output logic                    ar_pop_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [IdWidth-1:0]      meta_id_o,
  output logic                    meta_last_o,
  output logic [UserWidth-1:0]    meta_user_o,
  input  logic                    rsp_done_i,
  output logic                    busy_o,
  output ar_state_e               dbg_state_o
`ifdef AXI_AR_BURST_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_bursts_o,
  output logic [31:0]             perf_stall_o
`endif
);

  ar_state_e               state_q;
  logic [IdWidth-1:0]      id_q;
  logic [MemAddrWidth-1:0] addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [UserWidth-1:0]    user_q;
  logic [7:0]              beat_cnt_q;
  logic [CntWidth-1:0]     out_cnt_q;
  logic [MemAddrWidth-1:0] next_addr;
  logic                    accept;
  logic                    credit_ret;

  // Handshake: a beat transfers on a cycle with mem_req_o & mem_gnt_i; while
  // mem_req_o is high and mem_gnt_i low, address and meta are held (all come
  // from registers that only move on acceptance). ar_pop_o consumes the FIFO
  // head in the same cycle it is sampled.
  assign ar_pop_o    = rst_ni && (state_q == IDLE) && !ar_empty_i;
  assign mem_req_o   = (state_q == BURST) && (out_cnt_q < CntWidth'(MaxOutstanding));
  assign accept      = mem_req_o && mem_gnt_i;
  assign credit_ret  = rsp_done_i && (out_cnt_q != '0);
  assign mem_addr_o  = addr_q;
  assign meta_id_o   = id_q;
  assign meta_user_o = user_q;
  assign meta_last_o = (state_q == BURST) && (beat_cnt_q == len_q);
  assign busy_o      = (state_q == BURST) || (out_cnt_q != '0);
  assign dbg_state_o = state_q;

  axi_burst_addr_next #(
    .AddrWidth (MemAddrWidth)
  ) u_addr_next (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      user_q     <= '0;
      beat_cnt_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_pop_o) begin
            id_q       <= ar_id_i;
            addr_q     <= ar_addr_i;
            len_q      <= ar_len_i;
            size_q     <= ar_size_i;
            burst_q    <= ar_burst_i;
            user_q     <= ar_user_i;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            addr_q     <= next_addr;
            if (meta_last_o) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      case ({accept, credit_ret})
        2'b10:   out_cnt_q <= out_cnt_q + CntWidth'(1);
        2'b01:   out_cnt_q <= out_cnt_q - CntWidth'(1);
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

  // A retired beat with no beat outstanding indicates an R-path bookkeeping bug.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (MaxOutstanding >= 1 && DataWidth >= 8 && (DataWidth & (DataWidth - 1)) == 0);
      assert (!(rsp_done_i && out_cnt_q == '0));
    end
  end

`ifdef AXI_AR_BURST_SEQ_PERF_EN
  logic [31:0] perf_bursts_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_bursts_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (ar_pop_o && perf_bursts_q != '1) perf_bursts_q <= perf_bursts_q + 32'd1;
      if (state_q == BURST && !accept && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_bursts_o = perf_bursts_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: doc/axi_ar_burst_seq.md
Name: axi_ar_burst_seq

Overview:
Read-burst sequencer for the axi_to_mem read path. It pops AR requests from the AR channel FIFO (non-fall-through, empty/pop interface) and expands each AXI burst into single-beat memory read requests on a req/gnt port. It tags each beat with ID, last and user metadata for the R-path response buffer. A credit counter bounds the number of in-flight beats so that the response buffer cannot overflow.

Parameters:
IdWidth, 4, AXI ID width
MemAddrWidth, 32, address width
UserWidth, 1, AR user width
DataWidth, 64, memory data width in bits; must be a power of 2, at least 8
MaxOutstanding, 8, maximum accepted-but-unanswered beats; must be at least 1
CntWidth, $clog2(MaxOutstanding+1), credit counter width (derived)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ar_empty_i  in  1  AR FIFO empty
ar_id_i  in  IdWidth  head AR id
ar_addr_i  in  MemAddrWidth  head AR start address
ar_len_i  in  8  head AR beats minus 1
ar_size_i  in  3  head AR log2 bytes per beat
ar_burst_i  in  2  head AR burst type
ar_user_i  in  UserWidth  head AR user
ar_pop_o  out  1  pop the AR FIFO
mem_req_o  out  1  memory read request
mem_gnt_i  in  1  memory grant
mem_addr_o  out  MemAddrWidth  beat address
meta_id_o  out  IdWidth  beat id, valid with mem_req_o
meta_last_o  out  1  final beat of burst
meta_user_o  out  UserWidth  beat user
rsp_done_i  in  1  one beat retired by the R path
busy_o  out  1  burst in progress or beats outstanding

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i. Reset values: state=IDLE, all registers 0, ar_pop_o=0, mem_req_o=0, busy_o=0, all meta outputs 0. A reset mid-burst discards the burst; the FIFO entry that was already popped is lost.
- FSM IDLE:
  - When !ar_empty_i, ar_pop_o=1 for exactly one cycle (combinational from IDLE and !ar_empty_i).
  - In that same cycle, latch id, addr, len, size, burst and user; clear beat_cnt; go to BURST.
  - The FIFO head is valid whenever it is not empty, so no extra latency is needed.
- FSM BURST:
  - mem_req_o = (out_cnt < MaxOutstanding). There is no combinational path from rsp_done_i.
  - A beat is accepted on mem_req_o & mem_gnt_i.
  - On acceptance, beat_cnt increments and the address advances.
  - meta_last_o = (beat_cnt == len_q).
  - On acceptance of the last beat, return to IDLE.
  - Each burst incurs one IDLE bubble cycle. Latency: pop at cycle t, first mem_req_o at t+1.
- mem_addr_o, meta outputs and mem_req_o must stay stable while mem_req_o=1 and mem_gnt_i=0.
- Address update, with bytes = 1<<size_q and aligned = addr_q & ~(bytes-1):
  - FIXED (2'b00): addr_q is unchanged.
  - INCR (2'b01) and reserved (2'b11): next = aligned + bytes. The first beat may be unaligned; all later beats are aligned. There is no 4 KiB check.
  - WRAP (2'b10): with wsize = bytes*(len_q+1) and base = addr_q & ~(wsize-1), next = base | ((aligned + bytes) & (wsize-1)).
  - All arithmetic is modulo 2^MemAddrWidth.
  - size_q larger than log2(DataWidth/8) is passed through unchecked.
- Credits (out_cnt):
  - +1 on beat acceptance, -1 on rsp_done_i; a simultaneous acceptance and rsp_done_i leaves it unchanged.
  - rsp_done_i while out_cnt==0 is ignored, and a simulation assertion fires.
- busy_o = (state==BURST) | (out_cnt != 0).

Optional Feature:
AXI_AR_BURST_SEQ_PERF_EN:
- When defined, the block adds outputs perf_bursts_o[31:0] and perf_stall_o[31:0].
  - perf_bursts_o increments on each ar_pop_o.
  - perf_stall_o increments on each cycle with state==BURST and no accepted beat.
  - Both counters saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package axi_to_mem_pkg holds:
  - burst-type localparams BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10;
  - the FSM state enum (IDLE, BURST).
- One sub-module, axi_burst_addr_next: a combinational next-address calculator with inputs addr, size, len, burst and output next_addr. It is reusable by the write path.

Test Plan:
- INCR, addr=0x1003, len=3, size=2, mem_gnt_i held 1 -> pop at t, beats t+1..t+4 at 0x1003, 0x1004, 0x1008, 0x100C; last only on 0x100C.
- WRAP, addr=0x2034, len=3, size=2 -> beats 0x2034, 0x2038, 0x203C, 0x2030.
- FIXED, addr=0x40, len=2 -> three beats at 0x40; mem_gnt_i toggling 1/0 -> outputs stable during stalls.
- MaxOutstanding=2, rsp_done_i=0, len=4 -> only 2 beats accepted, mem_req_o=0. One rsp_done_i pulse -> exactly one more beat. A simultaneous gnt and rsp_done_i -> out_cnt unchanged.
- Two queued ARs (len=0 each) -> pops at t and t+2, single beats at t+1 and t+3, each with meta_last_o=1 and the correct IDs.
- rst_ni asserted mid-burst -> all outputs 0 immediately; after release, the next non-empty FIFO head is popped cleanly.
